// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   basic_data_t  : XLEN-wide data/address word.
//   branch_pred_t : prediction carried alongside a fetched instruction
//                   (same layout as decode's branchPredict field).
//   fetch_entry_t : one fetch-queue slot {pc, instr, done, pred}.
package fetch_unit_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    typedef logic [XLEN-1:0] basic_data_t;

    typedef struct packed {
        logic        taken;
        basic_data_t target;
    } branch_pred_t;

    typedef struct packed {
        basic_data_t  pc;
        logic [31:0]  instr;
        logic         done;
        branch_pred_t pred;
    } fetch_entry_t;

    // Instruction word presented to decode whenever no instruction is ready.
    localparam logic [31:0] NOP_BUBBLE = '0;

endpackage

// File: rtl/fetch_unit_queue.sv
// In-order circular buffer of fetch entries.
//   alloc / alloc_entry       : append an entry at the tail.
//   complete / complete_instr : fill the oldest not-yet-returned entry.
//   pop                       : retire the head entry.
//   clear                     : drop every entry (redirect).
//   head_entry / head_alloc   : head slot contents and whether it is allocated.
//   count / undone            : allocated entries / entries still awaiting data.
module fetch_unit_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc,
    input  fetch_entry_t  alloc_entry,
    input  logic          complete,
    input  logic [31:0]   complete_instr,
    input  logic          pop,
    input  logic          clear,
    output fetch_entry_t  head_entry,
    output logic          head_alloc,
    output logic [CW-1:0] count,
    output logic [CW-1:0] undone
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] cpl;    // oldest entry still waiting for its response

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            head   <= '0;
            tail   <= '0;
            cpl    <= '0;
            count  <= '0;
            undone <= '0;
        end else if (clear) begin
            head   <= '0;
            tail   <= '0;
            cpl    <= '0;
            count  <= '0;
            undone <= '0;
        end else begin
            if (alloc)    tail <= tail + 1'b1;
            if (pop)      head <= head + 1'b1;
            if (complete) cpl  <= cpl + 1'b1;
            count  <= count  + CW'(alloc) - CW'(pop);
            undone <= undone + CW'(alloc) - CW'(complete);
        end
    end

    // NOTE: the storage array has no reset; every read is qualified by count
    // and the done bit, so stale slot contents are never observable.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (alloc) mem[tail] <= alloc_entry;
            // Completion never targets the tail slot being allocated: it only
            // fires while at least one older entry is still undone.
            if (complete) begin
                mem[cpl].instr <= complete_instr;
                mem[cpl].done  <= 1'b1;
            end
        end
    end

    assign head_entry = mem[head];
    assign head_alloc = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch producer: owns the PC, issues imem requests, tracks
// in-flight requests and presents returned instructions in order to decode.
//   imemReq*      : request handshake, address is the current pc.
//   imemResp*     : in-order responses, never backpressured.
//   pred*         : same-cycle branch prediction for imemReqAddr.
//   redirect*     : controller flush/redirect, highest priority.
//   decodeStall   : decode holds its pipe register.
//   out*          : head instruction for decode; all zero when not valid.
//   fetchStall    : !outValid, decode inserts a bubble.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 2,
    parameter basic_data_t RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imemReqValid,
    input  logic            imemReqReady,
    output logic [XLEN-1:0] imemReqAddr,
    input  logic            imemRespValid,
    input  logic [31:0]     imemRespData,
    input  logic            predTaken,
    input  logic [XLEN-1:0] predTarget,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectPc,
    input  logic            decodeStall,
    output logic            outValid,
    output logic [XLEN-1:0] outPc,
    output logic [31:0]     outInstr,
    output logic            outPredTaken,
    output logic [XLEN-1:0] outPredTarget,
    output logic            fetchStall
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    basic_data_t   pc;
    logic [CW-1:0] squash_cnt;   // responses still owed to flushed requests
    logic [CW-1:0] entries;
    logic [CW-1:0] undone;
    logic [CW:0]   occupancy;
    logic          accept;
    logic          complete;
    logic          pop;
    logic          head_alloc;
    fetch_entry_t  head_entry;
    fetch_entry_t  alloc_entry;
    logic          unused_redirect_lsbs;

    // Squashed requests still hold a response slot, so they count against depth.
    assign occupancy    = {1'b0, entries} + {1'b0, squash_cnt};
    assign imemReqValid = !rst && !redirectValid && (occupancy < (CW+1)'(QUEUE_DEPTH));
    assign imemReqAddr  = pc;
    assign accept       = imemReqValid && imemReqReady;

    assign alloc_entry  = '{pc: pc, instr: '0, done: 1'b0,
                            pred: '{taken: predTaken, target: predTarget}};

    // A response during redirect is always discarded; otherwise squashed ones go first.
    assign complete = imemRespValid && !redirectValid && (squash_cnt == '0);
    assign pop      = outValid && !decodeStall && !redirectValid;

    assign unused_redirect_lsbs = ^redirectPc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            squash_cnt <= '0;
        end else if (redirectValid) begin
            pc         <= {redirectPc[XLEN-1:2], 2'b00};
            squash_cnt <= squash_cnt + undone - CW'(imemRespValid);
        end else begin
            if (accept)
                pc <= predTaken ? predTarget : pc + XLEN'(INSN_BYTES);
            if (imemRespValid && squash_cnt != '0)
                squash_cnt <= squash_cnt - 1'b1;
        end
    end

    fetch_unit_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk            (clk),
        .rst            (rst),
        .alloc          (accept),
        .alloc_entry    (alloc_entry),
        .complete       (complete),
        .complete_instr (imemRespData),
        .pop            (pop),
        .clear          (redirectValid),
        .head_entry     (head_entry),
        .head_alloc     (head_alloc),
        .count          (entries),
        .undone         (undone)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        outValid      = 1'b0;
        outPc         = '0;
        outInstr      = NOP_BUBBLE;
        outPredTaken  = 1'b0;
        outPredTarget = '0;
        if (head_alloc && head_entry.done) begin
            outValid      = 1'b1;
            outPc         = head_entry.pc;
            outInstr      = head_entry.instr;
            outPredTaken  = head_entry.pred.taken;
            outPredTarget = head_entry.pred.target;
        end
    end

    assign fetchStall = !outValid;

    occupancy_bound: assert property (@(posedge clk) disable iff (rst)
        occupancy <= (CW+1)'(QUEUE_DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReqValid, imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        decodeStall;
    logic        outValid;
    logic [31:0] outPc, outInstr, outPredTarget;
    logic        outPredTaken, fetchStall;

    fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .predTaken(predTaken), .predTarget(predTarget),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .decodeStall(decodeStall),
        .outValid(outValid), .outPc(outPc), .outInstr(outInstr),
        .outPredTaken(outPredTaken), .outPredTarget(outPredTarget),
        .fetchStall(fetchStall)
    );

    always #5 clk = ~clk;

    // Reference model: expected fetch stream and the memory's in-flight requests.
    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
        int          resp_cyc;   // cycle its response was delivered, -1 if pending
    } exp_t;

    typedef struct {
        int          id;
        int          epoch;
        int          due;
        logic [31:0] data;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          cyc = 0;
    int          epoch = 0;
    int          next_id = 0;
    int          last_due = 0;
    logic [31:0] model_pc;

    int checks = 0;
    int passed = 0;

    // Stimulus knobs, changed by the main sequence between cycles.
    int          ready_pct = 100, stall_pct = 0, redir_pct = 0, pred_pct = 0;
    int          lat_min = 1, lat_max = 1;
    bit          force_redir = 0, redir_on_resp = 0, pred_addr_en = 0;
    logic [31:0] force_pc = '0, pred_addr = '0, pred_tgt = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic idle_inputs();
        imemReqReady  = 1'b0;
        imemRespValid = 1'b0;
        imemRespData  = '0;
        predTaken     = 1'b0;
        predTarget    = '0;
        redirectValid = 1'b0;
        redirectPc    = '0;
        decodeStall   = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mem_q.delete();
        model_pc = RESET_PC;
        epoch++;
        last_due = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 128'(imemReqValid), 128'(1'b0));
        check({tag, "_out_valid"}, 128'(outValid), 128'(1'b0));
        check({tag, "_fetch_stall"}, 128'(fetchStall), 128'(1'b1));
        check({tag, "_out_fields"}, 128'({outPc, outInstr, outPredTaken, outPredTarget}), 128'(0));
    endtask

    // Driver: picks inputs on the falling edge, then applies the model rules
    // for the rising edge that follows.
    initial begin : driver
        bit          do_redir, resp, ready, take;
        logic [31:0] rpc, tgt;
        int          stale, due;
        bit          exp_valid;
        mem_t        m;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                idle_inputs();
                continue;
            end
            resp     = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
            do_redir = ($urandom_range(99) < redir_pct);
            rpc      = $urandom;
            if (force_redir) begin
                do_redir    = 1'b1;
                rpc         = force_pc;
                force_redir = 1'b0;
            end
            if (redir_on_resp && resp) begin
                do_redir      = 1'b1;
                rpc           = force_pc;
                redir_on_resp = 1'b0;
            end
            ready = ($urandom_range(99) < ready_pct);
            if (pred_addr_en && model_pc == pred_addr) begin
                take = 1'b1;
                tgt  = pred_tgt;
            end else begin
                take = ($urandom_range(99) < pred_pct);
                tgt  = $urandom & 32'hFFFF_FFFC;
            end

            imemRespValid = resp;
            imemRespData  = resp ? mem_q[0].data : $urandom;
            redirectValid = do_redir;
            redirectPc    = rpc;
            imemReqReady  = ready;
            decodeStall   = ($urandom_range(99) < stall_pct);
            predTaken     = take;
            predTarget    = tgt;

            #1;
            stale = 0;
            foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
            exp_valid = !do_redir && ((exp_q.size() + stale) < DEPTH);
            check("req_valid", 128'(imemReqValid), 128'(exp_valid));
            check("req_addr", 128'(imemReqAddr), 128'(model_pc));

            if (resp) begin
                assert (mem_q.size() > 0) else $error("response with nothing outstanding");
                m = mem_q.pop_front();
                if (!do_redir && m.epoch == epoch)
                    foreach (exp_q[i]) if (exp_q[i].id == m.id) exp_q[i].resp_cyc = cyc;
            end

            if (do_redir) begin
                exp_q.delete();
                epoch++;
                model_pc = rpc & 32'hFFFF_FFFC;
            end else if (exp_valid && ready) begin
                m.id    = next_id;
                m.epoch = epoch;
                m.data  = $urandom;
                due     = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.due    = due;
                mem_q.push_back(m);
                exp_q.push_back('{id: next_id, pc: model_pc, instr: m.data, taken: take,
                                  target: tgt, resp_cyc: -1});
                next_id++;
                model_pc = take ? tgt : model_pc + 32'd4;
            end
        end
    end

    // Monitor: compares what decode sees against the head of the expected stream.
    initial begin : monitor
        bit exp_ov;
        forever begin
            @(negedge clk);
            #2;
            if (rst || redirectValid) continue;
            exp_ov = (exp_q.size() > 0) && (exp_q[0].resp_cyc >= 0) && (exp_q[0].resp_cyc < cyc);
            check("out_valid", 128'(outValid), 128'(exp_ov));
            check("fetch_stall", 128'(fetchStall), 128'(!exp_ov));
            if (exp_ov) begin
                check("head", 128'({outPc, outInstr, outPredTaken, outPredTarget}),
                      128'({exp_q[0].pc, exp_q[0].instr, exp_q[0].taken, exp_q[0].target}));
                if (!decodeStall) void'(exp_q.pop_front());
            end else begin
                check("bubble", 128'({outPc, outInstr, outPredTaken, outPredTarget}), 128'(0));
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic set_mode(input int ready, input int stall, input int lmin, input int lmax);
        ready_pct = ready;
        stall_pct = stall;
        lat_min   = lmin;
        lat_max   = lmax;
    endtask

    task automatic drain();
        set_mode(0, 0, 1, 1);
        run(8);
    endtask

    initial begin : main
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check_reset_outputs("reset");
        run(2);
        rst = 1'b0;

        // Straight-line fetch, latency 1, no stall.
        set_mode(100, 0, 1, 1);
        run(12);

        // Decode stall fills the queue, then releases.
        set_mode(100, 100, 1, 1);
        run(6);
        set_mode(100, 0, 1, 1);
        run(6);

        // Taken prediction at 0x8 steers fetch to 0x100.
        force_redir  = 1'b1;
        force_pc     = 32'h0;
        pred_addr_en = 1'b1;
        pred_addr    = 32'h8;
        pred_tgt     = 32'h100;
        run(10);
        pred_addr_en = 1'b0;

        // Latency 3, two outstanding, redirect to an unaligned pc.
        drain();
        set_mode(100, 0, 3, 3);
        run(2);
        force_redir = 1'b1;
        force_pc    = 32'h203;
        run(14);

        // Redirect lands on a response while the queue is full and stalled.
        drain();
        set_mode(100, 100, 3, 3);
        redir_on_resp = 1'b1;
        force_pc      = 32'h40;
        run(8);
        set_mode(100, 0, 3, 3);
        run(10);

        // PC wraps from the top of the address space.
        force_redir = 1'b1;
        force_pc    = 32'hFFFF_FFFC;
        set_mode(100, 0, 1, 1);
        run(6);

        // Randomized traffic.
        set_mode(70, 30, 1, 4);
        redir_pct = 4;
        pred_pct  = 20;
        run(2000);
        redir_pct = 0;
        pred_pct  = 0;

        // Asynchronous reset with requests outstanding.
        set_mode(100, 0, 4, 4);
        run(3);
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("mid_reset");
        run(2);
        rst = 1'b0;
        set_mode(100, 0, 1, 1);
        run(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
